// File: rtl/flash_wip_poll.sv
// rtl/flash_wip_poll.sv - RDSR polling engine: repeats read-status frames until WIP clears
// Optional poll limit enabled by defining FLASH_POLL_TIMEOUT_EN.
module flash_wip_poll #(
    parameter logic [7:0] RDSR_INST    = 8'h05,
    parameter int         CS_SETUP_CYC = 4,
    parameter int         GAP_CYC      = 32
`ifdef FLASH_POLL_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_POLLS = 24'd2_000_000
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       miso,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] status,
    output logic       timeout
);

    localparam int CNT_MAX = (CS_SETUP_CYC > GAP_CYC)
                           ? ((CS_SETUP_CYC > 32) ? CS_SETUP_CYC : 32)
                           : ((GAP_CYC > 32) ? GAP_CYC : 32);
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        SETUP = 6'b000010,
        INST  = 6'b000100,
        READ  = 6'b001000,
        HOLD  = 6'b010000,
        GAP   = 6'b100000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         status_q, status_d;
    logic               sck_q, sck_d;
    logic               cs_n_q, cs_n_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_d;
`ifdef FLASH_POLL_TIMEOUT_EN
    logic               timeout_q;
    logic [23:0]        polls_q, polls_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        shift_d   = shift_q;
        status_d  = status_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
        polls_d   = polls_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SETUP;
`ifdef FLASH_POLL_TIMEOUT_EN
                    polls_d = '0;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    state_d = INST;
                    cnt_d   = '0;
                end
            end
            INST: begin
                if (cnt_q == CNT_W'(31)) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                // Sample on the edge that drops SCK, after a full high phase.
                if (cnt_q[1:0] == 2'd3) begin
                    shift_d = {shift_q[6:0], miso};
                end
                if (cnt_q == CNT_W'(31)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    status_d = shift_q;
                    cnt_d    = '0;
                    if (!shift_q[0]) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
`ifdef FLASH_POLL_TIMEOUT_EN
                        polls_d = polls_q + 24'd1;
                        if (polls_q + 24'd1 >= TIMEOUT_POLLS) begin
                            state_d   = IDLE;
                            timeout_d = 1'b1;
                        end
`endif
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Bus pins are registered from the next-state view so they line up with state_q.
        cs_n_d = !(state_d == SETUP || state_d == INST || state_d == READ || state_d == HOLD);
        sck_d  = (state_d == INST || state_d == READ) && cnt_d[1];
        mosi_d = (state_d == INST) ? RDSR_INST[3'd7 - cnt_d[4:2]] : 1'b0;
        busy_d = (state_d != IDLE) || done_d || timeout_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= 8'h00;
            status_q <= 8'h00;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            status_q <= status_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef FLASH_POLL_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timeout_q <= 1'b0;
            polls_q   <= 24'd0;
        end else begin
            timeout_q <= timeout_d;
            polls_q   <= polls_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign sck    = sck_q;
    assign cs_n   = cs_n_q;
    assign mosi   = mosi_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;

endmodule

// File: tb/tb_flash_wip_poll.sv
// tb/tb_flash_wip_poll.sv - self-checking bench for flash_wip_poll with an SPI flash status model
module tb_flash_wip_poll;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       miso = 1'b0;
    logic       sck, cs_n, mosi, busy, done, timeout;
    logic [7:0] status;

`ifdef FLASH_POLL_TIMEOUT_EN
    localparam int TO_POLLS = 5;

    flash_wip_poll #(.TIMEOUT_POLLS(24'd5)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .miso     (miso),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .timeout  (timeout)
    );
`else
    flash_wip_poll dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .miso     (miso),
        .sck      (sck),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .timeout  (timeout)
    );
`endif

    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] resp_arr [0:31];
    int         resp_n = 1;
    int         frames_seen = 0;
    bit         mon_en = 1'b0;
    logic       prev_cs = 1'b1, prev_sck = 1'b0;
    int         low_cnt = 0, high_cnt = 0, rises = 0;
    logic [7:0] cmd = 8'h00, cur_resp = 8'h00;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_cs  = 1'b1;
            prev_sck = 1'b0;
            miso     = 1'b0;
        end else begin
            if (prev_cs && !cs_n) begin
                if (mon_en && frames_seen > 0) chk("gap_high_cycles", high_cnt, 32);
                low_cnt  = 0;
                high_cnt = 0;
                rises    = 0;
                cmd      = 8'h00;
                cur_resp = (frames_seen < resp_n) ? resp_arr[frames_seen] : resp_arr[resp_n-1];
            end
            if (!cs_n) begin
                low_cnt++;
                if (!prev_sck && sck) begin
                    if (rises < 8) cmd = {cmd[6:0], mosi};
                    rises++;
                end
                if (prev_sck && !sck && rises >= 8 && rises <= 15) miso = cur_resp[15-rises];
            end else begin
                high_cnt++;
            end
            if (!prev_cs && cs_n) begin
                if (mon_en) begin
                    chk("frame_cs_low_cycles", low_cnt, 72);
                    chk("frame_sck_pulses", rises, 16);
                    chk("frame_instruction", cmd, 8'h05);
                end
                frames_seen++;
            end
            prev_cs  = cs_n;
            prev_sck = sck;
        end
    end

    function automatic void ref_model(output int fr, output logic [7:0] st, output bit to);
        fr = resp_n;
        st = resp_arr[resp_n-1];
        to = 1'b0;
        for (int i = 0; i < resp_n; i++) begin
            if (!resp_arr[i][0]) begin
                fr = i + 1;
                st = resp_arr[i];
                break;
            end
        end
`ifdef FLASH_POLL_TIMEOUT_EN
        if (fr > TO_POLLS) begin
            fr = TO_POLLS;
            st = resp_arr[TO_POLLS-1];
            to = 1'b1;
        end
`endif
    endfunction

    task automatic run_poll(input string tag, input bit extra, input int exp_fr,
                            input logic [7:0] exp_st, input bit exp_to);
        int k;
        int exp_k;
        int fr_end;
        frames_seen = 0;
        mon_en      = 1'b1;
        exp_k       = 72 * exp_fr + 32 * (exp_fr - 1);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        k = 0;
        chk({tag, "_busy_after_start"}, busy, 1'b1);
        chk({tag, "_cs_n_after_start"}, cs_n, 1'b0);
        while (!(done || timeout) && k < 6000) begin
            start = extra && (k == 40 || (exp_fr > 1 && k == 82));
            @(negedge sys_clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_end_cycle"}, k, exp_k);
        chk({tag, "_done"}, done, !exp_to);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_status"}, status, exp_st);
        chk({tag, "_busy_last"}, busy, 1'b1);
        @(negedge sys_clk);
        chk({tag, "_done_width"}, done, 1'b0);
        chk({tag, "_timeout_width"}, timeout, 1'b0);
        chk({tag, "_busy_released"}, busy, 1'b0);
        chk({tag, "_frames"}, frames_seen, exp_fr);
        fr_end = frames_seen;
        repeat (40) @(negedge sys_clk);
        chk({tag, "_idle_cs_n"}, cs_n, 1'b1);
        chk({tag, "_no_extra_frames"}, frames_seen, fr_end);
    endtask

    typedef struct {
        int         n_wip;
        logic [7:0] wip_byte;
        logic [7:0] final_byte;
        bit         extra;
        int         exp_frames;
        logic [7:0] exp_status;
        bit         exp_to;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int fr;
        logic [7:0] st;
        bit to;
        int nw;

        vecs[0] = '{0,  8'h01, 8'h00, 1'b0, 1,  8'h00, 1'b0};
        vecs[1] = '{3,  8'h03, 8'h02, 1'b0, 4,  8'h02, 1'b0};
        vecs[2] = '{3,  8'h03, 8'h02, 1'b1, 4,  8'h02, 1'b0};
        vecs[3] = '{1,  8'hFF, 8'hFE, 1'b1, 2,  8'hFE, 1'b0};
`ifdef FLASH_POLL_TIMEOUT_EN
        vecs[4] = '{10, 8'h01, 8'h00, 1'b0, 5,  8'h01, 1'b1};
        vecs[5] = '{10, 8'h01, 8'h00, 1'b0, 5,  8'h01, 1'b1};
`else
        vecs[4] = '{10, 8'h01, 8'h00, 1'b0, 11, 8'h00, 1'b0};
        vecs[5] = '{10, 8'h01, 8'h00, 1'b0, 11, 8'h00, 1'b0};
`endif
        vecs[6] = '{0,  8'h01, 8'h5A, 1'b0, 1,  8'h5A, 1'b0};

        repeat (3) @(negedge sys_clk);
        chk("reset_sck", sck, 1'b0);
        chk("reset_cs_n", cs_n, 1'b1);
        chk("reset_mosi", mosi, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_status", status, 8'h00);
        chk("reset_timeout", timeout, 1'b0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].n_wip; i++) resp_arr[i] = vecs[v].wip_byte;
            resp_arr[vecs[v].n_wip] = vecs[v].final_byte;
            resp_n = vecs[v].n_wip + 1;
            run_poll($sformatf("vec%0d", v), vecs[v].extra,
                     vecs[v].exp_frames, vecs[v].exp_status, vecs[v].exp_to);
        end

        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(0, 6);
            for (int i = 0; i < nw; i++) resp_arr[i] = 8'($urandom) | 8'h01;
            resp_arr[nw] = 8'($urandom) & 8'hFE;
            resp_n = nw + 1;
            ref_model(fr, st, to);
            run_poll($sformatf("rnd%0d", r), 1'($urandom), fr, st, to);
        end

        resp_arr[0] = 8'h00;
        resp_n = 1;
        mon_en = 1'b0;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (26) @(negedge sys_clk);
        chk("pre_abort_sck", sck, 1'b1);
        chk("pre_abort_mosi", mosi, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1'b1);
        chk("abort_sck", sck, 1'b0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_busy", busy, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        begin
            int done_seen = 0;
            int cs_low_seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge sys_clk);
                if (done) done_seen++;
                if (!cs_n) cs_low_seen++;
            end
            chk("abort_no_done", done_seen, 0);
            chk("abort_bus_idle", cs_low_seen, 0);
            chk("abort_status", status, 8'h00);
        end

        resp_arr[0] = 8'h01;
        resp_arr[1] = 8'h44;
        resp_n = 2;
        run_poll("recover", 1'b0, 2, 8'h44, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
